pipe_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 20 ++
 rtl/pipe_ctrl_reg_scoreboard.sv | 61 ++++++
 rtl/pipe_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_ctrl_pkg;

    localparam int REG_IDX_WIDTH = 5;
    localparam int PC_WIDTH      = 32;
    localparam int PERF_W        = 32;

    // Controller FSM encodings.
    typedef enum logic [1:0] {
        PCTL_RUN      = 2'd0,
        PCTL_MEM_WAIT = 2'd1,
        PCTL_ERR      = 2'd2
    } pctl_state_e;

    // x0 is hard-wired to zero, so it never carries a pending write.
    function automatic logic reg_tracked(input logic [REG_IDX_WIDTH-1:0] idx);
        return (idx != {REG_IDX_WIDTH{1'b0}});
    endfunction

endpackage

// File: rtl/pipe_ctrl_reg_scoreboard.sv
// Per-register pending-write counters used for read-after-write hazard detection.
// Lookups use the registered counts only; updates become visible next cycle.
module reg_scoreboard
    import pipe_ctrl_pkg::*;
#(
    parameter int NREG  = 32,
    parameter int CNT_W = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inc_en,
    input  logic [REG_IDX_WIDTH-1:0] inc_idx,
    input  logic                     dec_en,
    input  logic [REG_IDX_WIDTH-1:0] dec_idx,
    input  logic [REG_IDX_WIDTH-1:0] rs1_idx,
    input  logic [REG_IDX_WIDTH-1:0] rs2_idx,
    input  logic [REG_IDX_WIDTH-1:0] rd_idx,
    output logic                     rs1_busy,
    output logic                     rs2_busy,
    output logic                     rd_full
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [NREG-1:0][CNT_W-1:0] cnt;
    logic [NREG-1:0][CNT_W-1:0] cnt_next;

    // Next count per register: a matched increment and decrement cancel,
    // a decrement of an idle register is dropped, entry 0 stays at zero.
    always_comb begin
        cnt_next = cnt;
        for (int i = 1; i < NREG; i++) begin
            if (inc_en && (inc_idx == REG_IDX_WIDTH'(i)) &&
                !(dec_en && (dec_idx == REG_IDX_WIDTH'(i)))) begin
                cnt_next[i] = cnt[i] + CNT_W'(1'b1);
            end else if (dec_en && (dec_idx == REG_IDX_WIDTH'(i)) &&
                         !(inc_en && (inc_idx == REG_IDX_WIDTH'(i))) &&
                         (cnt[i] != CNT_ZERO)) begin
                cnt_next[i] = cnt[i] - CNT_W'(1'b1);
            end else begin
                cnt_next[i] = cnt[i];
            end
        end
        cnt_next[0] = CNT_ZERO;
    end

    // Counter array register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    assign rs1_busy = reg_tracked(rs1_idx) && (cnt[rs1_idx] != CNT_ZERO);
    assign rs2_busy = reg_tracked(rs2_idx) && (cnt[rs2_idx] != CNT_ZERO);
    assign rd_full  = reg_tracked(rd_idx)  && (cnt[rd_idx]  == CNT_MAX);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: memory-wait FSM with timeout, EX redirect,
// scoreboard-based data hazard stalls and stall/flush performance counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NREG        = 32,
    parameter int CNT_W       = 2,
    parameter int MEM_TIMEOUT = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dec_valid_i,
    input  logic [REG_IDX_WIDTH-1:0] dec_rs1_idx_i,
    input  logic [REG_IDX_WIDTH-1:0] dec_rs2_idx_i,
    input  logic                     dec_rs1_en_i,
    input  logic                     dec_rs2_en_i,
    input  logic [REG_IDX_WIDTH-1:0] dec_rd_idx_i,
    input  logic                     dec_rd_en_i,
    input  logic                     wb_en_i,
    input  logic [REG_IDX_WIDTH-1:0] wb_idx_i,
    input  logic                     ex_redirect_i,
    input  logic [PC_WIDTH-1:0]      ex_redirect_pc_i,
    input  logic                     mem_req_i,
    input  logic                     mem_ack_i,
    output logic                     stall_if_o,
    output logic                     stall_id_o,
    output logic                     stall_ex_o,
    output logic                     bubble_id_ex_o,
    output logic                     flush_if_id_o,
    output logic                     pc_redirect_en_o,
    output logic [PC_WIDTH-1:0]      pc_redirect_pc_o,
    output logic                     mem_err_o,
    output logic [PERF_W-1:0]        perf_stall_cnt_o,
    output logic [PERF_W-1:0]        perf_flush_cnt_o
);

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};

    pctl_state_e         state;
    pctl_state_e         state_next;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   wait_next;
    logic                mem_stall;
    logic                redirect;
    logic                hazard;
    logic                issue;
    logic                wb_dec;
    logic                rs1_busy;
    logic                rs2_busy;
    logic                rd_full;
    logic                mem_err;
    logic [PERF_W-1:0]   perf_stall;
    logic [PERF_W-1:0]   perf_flush;

    reg_scoreboard #(
        .NREG  (NREG),
        .CNT_W (CNT_W)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .inc_en   (issue),
        .inc_idx  (dec_rd_idx_i),
        .dec_en   (wb_dec),
        .dec_idx  (wb_idx_i),
        .rs1_idx  (dec_rs1_idx_i),
        .rs2_idx  (dec_rs2_idx_i),
        .rd_idx   (dec_rd_idx_i),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rd_full  (rd_full)
    );

    // Hazard uses registered counts only: a same-cycle writeback does not help
    // because the register file has no write-through path.
    assign hazard = dec_valid_i && ((dec_rs1_en_i && rs1_busy) ||
                                    (dec_rs2_en_i && rs2_busy) ||
                                    (dec_rd_en_i  && rd_full));
    assign wb_dec = wb_en_i && reg_tracked(wb_idx_i);

    // FSM next state plus stall/bubble/flush/redirect priority:
    // reset, then memory stall, then redirect, then data hazard.
    always_comb begin
        state_next       = state;
        wait_next        = wait_cnt;
        stall_if_o       = 1'b0;
        stall_id_o       = 1'b0;
        stall_ex_o       = 1'b0;
        bubble_id_ex_o   = 1'b0;
        flush_if_id_o    = 1'b0;
        pc_redirect_en_o = 1'b0;

        mem_stall = (mem_req_i && !mem_ack_i) || (state == PCTL_ERR);
        redirect  = ex_redirect_i && !mem_stall;
        issue     = dec_valid_i && dec_rd_en_i && reg_tracked(dec_rd_idx_i) &&
                    !hazard && !mem_stall && !redirect && !rst;

        case (state)
            PCTL_RUN: begin
                if (mem_req_i && !mem_ack_i) begin
                    state_next = PCTL_MEM_WAIT;
                    wait_next  = WAIT_ZERO;
                end else begin
                    state_next = PCTL_RUN;
                    wait_next  = WAIT_ZERO;
                end
            end
            PCTL_MEM_WAIT: begin
                if (mem_ack_i) begin
                    state_next = PCTL_RUN;
                    wait_next  = WAIT_ZERO;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = PCTL_ERR;
                    wait_next  = WAIT_ZERO;
                end else begin
                    state_next = PCTL_MEM_WAIT;
                    wait_next  = wait_cnt + WAIT_W'(1'b1);
                end
            end
            PCTL_ERR: begin
                state_next = PCTL_ERR;
                wait_next  = WAIT_ZERO;
            end
            default: begin
                state_next = PCTL_RUN;
                wait_next  = WAIT_ZERO;
            end
        endcase

        if (rst) begin
            flush_if_id_o  = 1'b1;
            bubble_id_ex_o = 1'b1;
        end else if (mem_stall) begin
            stall_if_o = 1'b1;
            stall_id_o = 1'b1;
            stall_ex_o = 1'b1;
        end else if (redirect) begin
            pc_redirect_en_o = 1'b1;
            flush_if_id_o    = 1'b1;
            bubble_id_ex_o   = 1'b1;
        end else if (hazard) begin
            stall_if_o     = 1'b1;
            stall_id_o     = 1'b1;
            bubble_id_ex_o = 1'b1;
        end else begin
            stall_if_o = 1'b0;
        end
    end

    // FSM state and memory wait counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= PCTL_RUN;
            wait_cnt <= WAIT_ZERO;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

    // Sticky memory-timeout flag, set on the edge that enters ERR.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_err <= 1'b0;
        end else if (state_next == PCTL_ERR) begin
            mem_err <= 1'b1;
        end else begin
            mem_err <= mem_err;
        end
    end

    // Free-running wrap-around stall and redirect counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall <= 32'd0;
            perf_flush <= 32'd0;
        end else begin
            if (stall_if_o) begin
                perf_stall <= perf_stall + 32'd1;
            end else begin
                perf_stall <= perf_stall;
            end
            if (pc_redirect_en_o) begin
                perf_flush <= perf_flush + 32'd1;
            end else begin
                perf_flush <= perf_flush;
            end
        end
    end

    assign pc_redirect_pc_o = ex_redirect_pc_i;
    assign mem_err_o        = mem_err;
    assign perf_stall_cnt_o = perf_stall;
    assign perf_flush_cnt_o = perf_flush;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized
// traffic compared against a behavioural model of the sequencing rules.
module tb_pipe_ctrl;

    localparam int TIMEOUT = 4;
    localparam int MAXCNT  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid_i;
    logic [4:0]  dec_rs1_idx_i, dec_rs2_idx_i, dec_rd_idx_i, wb_idx_i;
    logic        dec_rs1_en_i, dec_rs2_en_i, dec_rd_en_i, wb_en_i;
    logic        ex_redirect_i;
    logic [31:0] ex_redirect_pc_i;
    logic        mem_req_i, mem_ack_i;
    logic        stall_if_o, stall_id_o, stall_ex_o, bubble_id_ex_o, flush_if_id_o;
    logic        pc_redirect_en_o, mem_err_o;
    logic [31:0] pc_redirect_pc_o, perf_stall_cnt_o, perf_flush_cnt_o;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          pend [32];
    bit          m_wait, m_err;
    int          m_waited;
    logic [31:0] m_stall_cnt, m_flush_cnt;
    bit          exp_stall_if, exp_stall_id, exp_stall_ex, exp_bubble, exp_flush, exp_redir;
    bit          m_issue;

    pipe_ctrl #(.NREG(32), .CNT_W(2), .MEM_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .dec_valid_i(dec_valid_i), .dec_rs1_idx_i(dec_rs1_idx_i), .dec_rs2_idx_i(dec_rs2_idx_i),
        .dec_rs1_en_i(dec_rs1_en_i), .dec_rs2_en_i(dec_rs2_en_i),
        .dec_rd_idx_i(dec_rd_idx_i), .dec_rd_en_i(dec_rd_en_i),
        .wb_en_i(wb_en_i), .wb_idx_i(wb_idx_i),
        .ex_redirect_i(ex_redirect_i), .ex_redirect_pc_i(ex_redirect_pc_i),
        .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
        .stall_if_o(stall_if_o), .stall_id_o(stall_id_o), .stall_ex_o(stall_ex_o),
        .bubble_id_ex_o(bubble_id_ex_o), .flush_if_id_o(flush_if_id_o),
        .pc_redirect_en_o(pc_redirect_en_o), .pc_redirect_pc_o(pc_redirect_pc_o),
        .mem_err_o(mem_err_o), .perf_stall_cnt_o(perf_stall_cnt_o),
        .perf_flush_cnt_o(perf_flush_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        dec_valid_i = 0; dec_rs1_idx_i = 0; dec_rs2_idx_i = 0; dec_rd_idx_i = 0;
        dec_rs1_en_i = 0; dec_rs2_en_i = 0; dec_rd_en_i = 0;
        wb_en_i = 0; wb_idx_i = 0; ex_redirect_i = 0; ex_redirect_pc_i = 32'h0;
        mem_req_i = 0; mem_ack_i = 0;
    endtask

    task automatic set_dec(input bit v, input bit r1e, input int r1, input bit r2e, input int r2,
                           input bit rde, input int rd);
        dec_valid_i = v; dec_rs1_en_i = r1e; dec_rs1_idx_i = 5'(r1);
        dec_rs2_en_i = r2e; dec_rs2_idx_i = 5'(r2); dec_rd_en_i = rde; dec_rd_idx_i = 5'(rd);
    endtask

    // Expected combinational outputs for the current inputs and model state.
    task automatic model_eval();
        bit ms, hz;
        exp_stall_if = 0; exp_stall_id = 0; exp_stall_ex = 0;
        exp_bubble = 0; exp_flush = 0; exp_redir = 0; m_issue = 0;
        if (rst) begin
            exp_flush = 1; exp_bubble = 1;
        end else begin
            ms = (mem_req_i && !mem_ack_i) || m_err;
            hz = dec_valid_i && ((dec_rs1_en_i && dec_rs1_idx_i != 0 && pend[dec_rs1_idx_i] > 0) ||
                                 (dec_rs2_en_i && dec_rs2_idx_i != 0 && pend[dec_rs2_idx_i] > 0) ||
                                 (dec_rd_en_i && dec_rd_idx_i != 0 && pend[dec_rd_idx_i] == MAXCNT));
            if (ms) begin
                exp_stall_if = 1; exp_stall_id = 1; exp_stall_ex = 1;
            end else if (ex_redirect_i) begin
                exp_redir = 1; exp_flush = 1; exp_bubble = 1;
            end else if (hz) begin
                exp_stall_if = 1; exp_stall_id = 1; exp_bubble = 1;
            end
            m_issue = dec_valid_i && dec_rd_en_i && dec_rd_idx_i != 0 && !hz && !ms && !ex_redirect_i;
        end
    endtask

    // Advance the model across the coming clock edge.
    task automatic model_commit();
        bit dec;
        if (rst) begin
            for (int i = 0; i < 32; i++) pend[i] = 0;
            m_wait = 0; m_err = 0; m_waited = 0; m_stall_cnt = 0; m_flush_cnt = 0;
            return;
        end
        if (exp_stall_if) m_stall_cnt = m_stall_cnt + 1;
        if (exp_redir) m_flush_cnt = m_flush_cnt + 1;
        dec = wb_en_i && wb_idx_i != 0;
        if (!(m_issue && dec && dec_rd_idx_i == wb_idx_i)) begin
            if (m_issue) pend[dec_rd_idx_i]++;
            if (dec && pend[wb_idx_i] > 0) pend[wb_idx_i]--;
        end
        if (!m_err) begin
            if (m_wait) begin
                if (mem_ack_i) m_wait = 0;
                else begin
                    m_waited++;
                    if (m_waited == TIMEOUT) begin m_err = 1; m_wait = 0; end
                end
            end else if (mem_req_i && !mem_ack_i) begin
                m_wait = 1; m_waited = 0;
            end
        end
    endtask

    task automatic eval_cycle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic end_cycle();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        eval_cycle();
        end_cycle();
        rst = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        ex_redirect_pc_i = 32'hCAFE_0004;
        rst = 1;
        for (int c = 0; c < 2; c++) begin
            eval_cycle();
            checks++; if (flush_if_id_o !== 1'b1) begin errors++; $display("FAIL rst_flush got %b want 1", flush_if_id_o); end
            checks++; if (bubble_id_ex_o !== 1'b1) begin errors++; $display("FAIL rst_bubble got %b want 1", bubble_id_ex_o); end
            checks++; if ({stall_if_o, stall_id_o, stall_ex_o, pc_redirect_en_o} !== 4'b0000) begin
                errors++; $display("FAIL rst_stalls got %b want 0000", {stall_if_o, stall_id_o, stall_ex_o, pc_redirect_en_o}); end
            end_cycle();
        end
        rst = 0;
        eval_cycle();
        checks++; if (mem_err_o !== 1'b0) begin errors++; $display("FAIL rst_mem_err got %b want 0", mem_err_o); end
        checks++; if (perf_stall_cnt_o !== 32'd0 || perf_flush_cnt_o !== 32'd0) begin
            errors++; $display("FAIL rst_perf got %0d/%0d want 0/0", perf_stall_cnt_o, perf_flush_cnt_o); end
        checks++; if (pc_redirect_pc_o !== 32'hCAFE_0004) begin errors++; $display("FAIL rst_pc got %h want cafe0004", pc_redirect_pc_o); end
        end_cycle();
    endtask

    task automatic test_dependent_pair();
        do_reset();
        set_dec(1, 0, 0, 0, 0, 1, 5);
        eval_cycle();
        checks++; if (stall_if_o !== 1'b0) begin errors++; $display("FAIL dep_issue got %b want 0", stall_if_o); end
        end_cycle();
        set_dec(1, 1, 5, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            wb_en_i = (c == 3); wb_idx_i = 5'd5;
            eval_cycle();
            checks++; if ({stall_if_o, stall_id_o, bubble_id_ex_o, stall_ex_o} !== 4'b1110) begin
                errors++; $display("FAIL dep_stall cyc %0d got %b want 1110", c, {stall_if_o, stall_id_o, bubble_id_ex_o, stall_ex_o}); end
            end_cycle();
        end
        wb_en_i = 0;
        eval_cycle();
        checks++; if ({stall_if_o, bubble_id_ex_o} !== 2'b00) begin
            errors++; $display("FAIL dep_release got %b want 00", {stall_if_o, bubble_id_ex_o}); end
        end_cycle();
        set_dec(1, 0, 0, 1, 5, 0, 0);
        eval_cycle();
        checks++; if (stall_if_o !== 1'b0) begin errors++; $display("FAIL dep_cnt_zero got %b want 0", stall_if_o); end
        end_cycle();
        clear_inputs();
    endtask

    task automatic test_x0();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            set_dec(1, 1, 0, 1, 0, 1, 0);
            eval_cycle();
            checks++; if (stall_if_o !== 1'b0 || bubble_id_ex_o !== 1'b0) begin
                errors++; $display("FAIL x0_nostall cyc %0d got %b%b want 00", c, stall_if_o, bubble_id_ex_o); end
            end_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req_i = 1; mem_ack_i = 0;
        set_dec(1, 0, 0, 0, 0, 1, 3);
        for (int c = 0; c < 3; c++) begin
            eval_cycle();
            checks++; if ({stall_if_o, stall_id_o, stall_ex_o, bubble_id_ex_o, flush_if_id_o} !== 5'b11100) begin
                errors++; $display("FAIL memw_stall cyc %0d got %b want 11100", c,
                                   {stall_if_o, stall_id_o, stall_ex_o, bubble_id_ex_o, flush_if_id_o}); end
            end_cycle();
        end
        mem_ack_i = 1;
        eval_cycle();
        checks++; if ({stall_if_o, stall_id_o, stall_ex_o} !== 3'b000) begin
            errors++; $display("FAIL memw_ack got %b want 000", {stall_if_o, stall_id_o, stall_ex_o}); end
        checks++; if (perf_stall_cnt_o !== 32'd3) begin errors++; $display("FAIL memw_perf got %0d want 3", perf_stall_cnt_o); end
        end_cycle();
        clear_inputs();
        eval_cycle();
        checks++; if (perf_stall_cnt_o !== 32'd3 || mem_err_o !== 1'b0) begin
            errors++; $display("FAIL memw_after got %0d/%b want 3/0", perf_stall_cnt_o, mem_err_o); end
        end_cycle();
    endtask

    task automatic test_redirect_stall();
        do_reset();
        set_dec(1, 0, 0, 0, 0, 1, 9);
        eval_cycle(); end_cycle();
        set_dec(1, 1, 9, 0, 0, 1, 10);
        mem_req_i = 1; mem_ack_i = 0; ex_redirect_i = 1; ex_redirect_pc_i = 32'h0000_0100;
        eval_cycle();
        checks++; if ({pc_redirect_en_o, flush_if_id_o, stall_if_o} !== 3'b001) begin
            errors++; $display("FAIL redir_suppr got %b want 001", {pc_redirect_en_o, flush_if_id_o, stall_if_o}); end
        end_cycle();
        mem_ack_i = 1;
        eval_cycle();
        checks++; if ({pc_redirect_en_o, flush_if_id_o, bubble_id_ex_o, stall_if_o} !== 4'b1110) begin
            errors++; $display("FAIL redir_apply got %b want 1110", {pc_redirect_en_o, flush_if_id_o, bubble_id_ex_o, stall_if_o}); end
        checks++; if (pc_redirect_pc_o !== 32'h0000_0100) begin errors++; $display("FAIL redir_pc got %h want 100", pc_redirect_pc_o); end
        end_cycle();
        clear_inputs();
        set_dec(1, 1, 10, 0, 0, 0, 0);
        eval_cycle();
        checks++; if (perf_flush_cnt_o !== 32'd1) begin errors++; $display("FAIL redir_perf got %0d want 1", perf_flush_cnt_o); end
        checks++; if (stall_if_o !== 1'b0) begin errors++; $display("FAIL redir_squash got %b want 0", stall_if_o); end
        end_cycle();
        clear_inputs();
    endtask

    task automatic test_saturation();
        bit want [8];
        want = '{0, 0, 0, 1, 1, 0, 0, 1};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            set_dec(1, 0, 0, 0, 0, 1, 7);
            wb_en_i = (c == 4 || c == 5); wb_idx_i = 5'd7;
            eval_cycle();
            checks++; if (stall_if_o !== want[c]) begin
                errors++; $display("FAIL sat_x7 cyc %0d got %b want %b", c, stall_if_o, want[c]); end
            end_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        mem_req_i = 1; mem_ack_i = 0;
        for (int c = 0; c <= TIMEOUT; c++) begin
            eval_cycle();
            checks++; if (mem_err_o !== 1'b0) begin errors++; $display("FAIL tmo_early cyc %0d got %b want 0", c, mem_err_o); end
            end_cycle();
        end
        mem_req_i = 0;
        eval_cycle();
        checks++; if (mem_err_o !== 1'b1) begin errors++; $display("FAIL tmo_err got %b want 1", mem_err_o); end
        checks++; if ({stall_if_o, stall_id_o, stall_ex_o} !== 3'b111) begin
            errors++; $display("FAIL tmo_stall got %b want 111", {stall_if_o, stall_id_o, stall_ex_o}); end
        end_cycle();
        rst = 1;
        eval_cycle();
        checks++; if (stall_if_o !== 1'b0 || flush_if_id_o !== 1'b1) begin
            errors++; $display("FAIL tmo_rst got %b%b want 01", stall_if_o, flush_if_id_o); end
        end_cycle();
        rst = 0;
        eval_cycle();
        checks++; if (mem_err_o !== 1'b0 || stall_if_o !== 1'b0) begin
            errors++; $display("FAIL tmo_clear got %b%b want 00", mem_err_o, stall_if_o); end
        end_cycle();
    endtask

    task automatic test_random();
        int mem_left = 0;
        int start, r;
        bit found;
        do_reset();
        for (int c = 0; c < 500; c++) begin
            set_dec($urandom_range(0, 4) != 0, $urandom_range(0, 1), $urandom_range(0, 7),
                    $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 2) != 0, $urandom_range(0, 7));
            if (mem_left == 0 && $urandom_range(0, 5) == 0) mem_left = $urandom_range(1, 4);
            if (mem_left > 0) begin
                mem_req_i = 1; mem_ack_i = (mem_left == 1); mem_left--;
            end else begin
                mem_req_i = 0; mem_ack_i = 0;
            end
            ex_redirect_i = ($urandom_range(0, 7) == 0);
            ex_redirect_pc_i = $urandom;
            wb_en_i = 0; wb_idx_i = 0;
            if ($urandom_range(0, 1) == 1) begin
                start = $urandom_range(0, 30); found = 0;
                for (int k = 0; k < 31; k++) begin
                    r = 1 + ((start + k) % 31);
                    if (!found && pend[r] > 0) begin found = 1; wb_en_i = 1; wb_idx_i = 5'(r); end
                end
            end else if ($urandom_range(0, 15) == 0) begin
                wb_en_i = 1; wb_idx_i = 5'd0;
            end
            eval_cycle();
            checks++; if ({stall_if_o, stall_id_o, stall_ex_o} !== {exp_stall_if, exp_stall_id, exp_stall_ex}) begin
                errors++; $display("FAIL rnd_stall cyc %0d got %b want %b", c, {stall_if_o, stall_id_o, stall_ex_o},
                                   {exp_stall_if, exp_stall_id, exp_stall_ex}); end
            checks++; if ({bubble_id_ex_o, flush_if_id_o, pc_redirect_en_o} !== {exp_bubble, exp_flush, exp_redir}) begin
                errors++; $display("FAIL rnd_ctl cyc %0d got %b want %b", c, {bubble_id_ex_o, flush_if_id_o, pc_redirect_en_o},
                                   {exp_bubble, exp_flush, exp_redir}); end
            checks++; if (pc_redirect_pc_o !== ex_redirect_pc_i) begin
                errors++; $display("FAIL rnd_pc cyc %0d got %h want %h", c, pc_redirect_pc_o, ex_redirect_pc_i); end
            checks++; if (perf_stall_cnt_o !== m_stall_cnt || perf_flush_cnt_o !== m_flush_cnt) begin
                errors++; $display("FAIL rnd_perf cyc %0d got %0d/%0d want %0d/%0d", c, perf_stall_cnt_o, perf_flush_cnt_o,
                                   m_stall_cnt, m_flush_cnt); end
            checks++; if (mem_err_o !== m_err) begin
                errors++; $display("FAIL rnd_err cyc %0d got %b want %b", c, mem_err_o, m_err); end
            end_cycle();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        test_reset();
        test_dependent_pair();
        test_x0();
        test_mem_wait();
        test_redirect_stall();
        test_saturation();
        test_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
